// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types and constants for the trace capture sequencer.
package trace_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic TRIG_SRC_MATCH = 1'b0;
  localparam logic TRIG_SRC_M3    = 1'b1;

endpackage

// File: rtl/trace_trig_stretch.sv
// Loadable down-counter that stretches the capture-start event into the trigger-out pulse.
module trace_trig_stretch #(
  parameter int W = 8
) (
  input  logic         trace_clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         clear,
  input  logic [W-1:0] len,
  output logic         trig_out
);

  logic [W-1:0] cnt;

  // clear beats start so an abort on the capture-entry edge leaves no pulse
  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn)          cnt <= '0;
    else if (clear)       cnt <= '0;
    else if (start)       cnt <= len;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign trig_out = (cnt != '0);

endmodule

// File: rtl/trace_capture_ctrl.sv
// Arm/trigger/delay/capture/done sequencer gating trace words into the capture FIFO.
module trace_capture_ctrl
  import trace_capture_ctrl_pkg::*;
#(
  parameter int pCAPTURE_LEN_WIDTH = 20,
  parameter int pDELAY_WIDTH       = 16,
  parameter int pTRIG_PULSE_WIDTH  = 8
) (
  input  logic                          trace_clk,
  input  logic                          resetn,
  input  logic                          I_arm,
  input  logic                          I_abort,
  input  logic                          I_trig_src,
  input  logic                          I_match,
  input  logic                          I_m3_trig,
  input  logic [pDELAY_WIDTH-1:0]       I_delay,
  input  logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_len,
  input  logic [pTRIG_PULSE_WIDTH-1:0]  I_trig_pulse_len,
  input  logic                          I_data_valid,
  input  logic                          I_fifo_full,
  output logic                          O_fifo_wr,
  output logic                          O_trig_out,
  output logic                          O_arm,
  output logic                          O_capturing,
  output logic                          O_done,
  output logic                          O_overflow,
  output logic [pCAPTURE_LEN_WIDTH-1:0] O_words
);

  localparam int LW = pCAPTURE_LEN_WIDTH;
  localparam int DW = pDELAY_WIDTH;
  localparam int PW = pTRIG_PULSE_WIDTH;

  state_t          state, state_nxt;
  logic            src_q, m3_q, overflow;
  logic [DW-1:0]   delay_q, dcnt;
  logic [LW-1:0]   len_q, words, words_inc;
  logic [PW-1:0]   plen_q;
  logic            trig_evt, arm_acc, cap_start, words_hit;

  // m3_q tracks the pin every cycle, so a level already high at arm is not an edge
  assign trig_evt  = (src_q == TRIG_SRC_M3) ? (I_m3_trig & ~m3_q) : I_match;
  assign arm_acc   = I_arm & ~I_abort & ((state == ST_IDLE) | (state == ST_DONE));
  assign O_fifo_wr = I_data_valid & ~I_fifo_full & (state == ST_CAPTURE);
  assign words_inc = (&words) ? words : words + LW'(1);
  assign words_hit = O_fifo_wr & (len_q != '0) & (words_inc == len_q);
  assign cap_start = (state_nxt == ST_CAPTURE) & (state != ST_CAPTURE);

  always_comb begin
    state_nxt = state;
    if (I_abort) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE, ST_DONE: if (I_arm) state_nxt = ST_ARMED;
        ST_ARMED:         if (trig_evt) state_nxt = (delay_q == '0) ? ST_CAPTURE : ST_DELAY;
        ST_DELAY:         if (dcnt <= DW'(1)) state_nxt = ST_CAPTURE;
        ST_CAPTURE:       if (words_hit) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      m3_q     <= 1'b0;
      src_q    <= 1'b0;
      delay_q  <= '0;
      len_q    <= '0;
      plen_q   <= '0;
      dcnt     <= '0;
      words    <= '0;
      overflow <= 1'b0;
    end else begin
      m3_q <= I_m3_trig;
      if (arm_acc) begin
        src_q    <= I_trig_src;
        delay_q  <= I_delay;
        len_q    <= I_capture_len;
        plen_q   <= I_trig_pulse_len;
        words    <= '0;
        overflow <= 1'b0;
      end else begin
        if (O_fifo_wr) words <= words_inc;
        if ((state == ST_CAPTURE) & I_data_valid & I_fifo_full) overflow <= 1'b1;
      end
      if (I_abort)                                   dcnt <= '0;
      else if ((state == ST_ARMED) & trig_evt)       dcnt <= delay_q;
      else if ((state == ST_DELAY) & (dcnt != '0))   dcnt <= dcnt - DW'(1);
    end
  end

  trace_trig_stretch #(.W(PW)) u_stretch (
    .trace_clk (trace_clk),
    .resetn    (resetn),
    .start     (cap_start),
    .clear     (I_abort),
    .len       (plen_q),
    .trig_out  (O_trig_out)
  );

  assign O_arm       = (state == ST_ARMED) | (state == ST_DELAY);
  assign O_capturing = (state == ST_CAPTURE);
  assign O_done      = (state == ST_DONE);
  assign O_overflow  = overflow;
  assign O_words     = words;

endmodule
